// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate tick, registered h/v sync, active-video flag and pixel coordinates.
// Optional `VGA_FRAME_TICK_EN adds a registered once-per-frame pulse output frame_tick.
module vga_timing_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   TICK_DIV    = 4,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP_C = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_C = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_d;
    logic             p_tick_q;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    // Counters step in the clk where p_tick is high; sync is decoded from the next-state
    // counts so it updates on the same edge as pixel_x/pixel_y.
    always_comb begin
        tick_d = (div_q == DIV_LAST);
        div_d  = tick_d ? '0 : div_q + 1'b1;
        h_d    = h_q;
        v_d    = v_q;
        if (p_tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        hsync_d = ((h_d >= HS_START) && (h_d <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((v_d >= VS_START) && (v_d <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= ~SYNC_ACTIVE;
            vsync_q  <= ~SYNC_ACTIVE;
        end else begin
            div_q    <= div_d;
            p_tick_q <= tick_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic frame_tick_q;

    // Pulses alongside the p_tick whose end-of-clk edge wraps the raster to (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= tick_d && (h_q == H_LAST) && (v_q == V_LAST);
        end
    end

    assign frame_tick = frame_tick_q;
`endif

    assign p_tick   = p_tick_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign pixel_x  = h_q;
    assign pixel_y  = v_q;
    assign video_on = (h_q < H_DISP_C) && (v_q < V_DISP_C);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny, active-high-sync
// instance (15x9 raster, /3 divider) small enough to run whole frames.
module tb_vga_timing_gen;

    logic       clk;
    logic       reset;
    logic       hsync, vsync, video_on, p_tick;
    logic [9:0] pixel_x, pixel_y;
    logic       hsync2, vsync2, video_on2, p_tick2;
    logic [9:0] pixel_x2, pixel_y2;
`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick, frame_tick2;
    int         ft_main_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    vga_timing_gen dut (
        .clk      (clk),
        .reset    (reset),
        .hsync    (hsync),
        .vsync    (vsync),
        .video_on (video_on),
        .p_tick   (p_tick),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick (frame_tick)
`endif
    );

    vga_timing_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .TICK_DIV  (3), .SYNC_ACTIVE (1'b1)
    ) dut2 (
        .clk      (clk),
        .reset    (reset),
        .hsync    (hsync2),
        .vsync    (vsync2),
        .video_on (video_on2),
        .p_tick   (p_tick2),
        .pixel_x  (pixel_x2),
        .pixel_y  (pixel_y2)
`ifdef VGA_FRAME_TICK_EN
        ,
        .frame_tick (frame_tick2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VGA_FRAME_TICK_EN
    initial ft_main_cnt = 0;
    always @(negedge clk) if (frame_tick) ft_main_cnt = ft_main_cnt + 1;
`endif

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_main(input int x, input int y, input int budget, input string tag);
        int n = 0;
        while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (pixel_x == 10'(x) && pixel_y == 10'(y)) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int t_rise;

        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_x", pixel_x, 0);
        chk("rst_y", pixel_y, 0);
        chk("rst_ptick", p_tick, 0);
        chk("rst_video_on", video_on, 1);
        chk("rst_hsync2_inactive", hsync2, 0);
        chk("rst_vsync2_inactive", vsync2, 0);
`ifdef VGA_FRAME_TICK_EN
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_frame_tick2", frame_tick2, 0);
`endif
        reset = 1'b0;

        // p_tick after posedge k is high only for k = 4, 8, 12.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("ptick_k%0d", k), p_tick, (k % 4 == 0) ? 1 : 0);
        end
        chk("x_after_12clk", pixel_x, 2);
        chk("y_after_12clk", pixel_y, 0);
        chk("x2_after_12clk", pixel_x2, 3);

        wait_main(639, 0, 4000, "reach_639");
        chk("video_on_x639", video_on, 1);
        repeat (4) @(negedge clk);
        chk("x_after_639", pixel_x, 640);
        chk("video_on_x640", video_on, 0);

        wait_main(655, 0, 100, "reach_655");
        chk("hsync_x655", hsync, 1);
        n = 0;
        while (hsync == 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("hsync_fall_x", pixel_x, 656);
        n = 0;
        while (hsync == 1'b0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("hsync_low_clks", n, 384);
        chk("hsync_rise_x", pixel_x, 752);

        wait_main(799, 0, 400, "reach_799");
        chk("video_on_x799", video_on, 0);
        repeat (4) @(negedge clk);
        chk("wrap_x", pixel_x, 0);
        chk("wrap_y", pixel_y, 1);
        chk("video_on_x0_y1", video_on, 1);
        chk("vsync_y1", vsync, 1);
        n = 0;
        while (pixel_x == 10'd0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pixel_hold_clks", n, 4);

        // Asynchronous reset between clock edges at pixel (300,1).
        wait_main(300, 1, 1500, "reach_300_1");
        #2 reset = 1'b1;
        #1;
        chk("arst_x", pixel_x, 0);
        chk("arst_y", pixel_y, 0);
        chk("arst_hsync", hsync, 1);
        chk("arst_vsync", vsync, 1);
        chk("arst_ptick", p_tick, 0);
        chk("arst_video_on", video_on, 1);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (p_tick == 1'b0 && n < 20);
        chk("arst_first_tick", n, 4);
        chk("arst_x_at_tick", pixel_x, 0);
        @(negedge clk);
        chk("arst_x_after_tick", pixel_x, 1);

        // Small raster: hsync2 active high for h in 10..12, vsync2 for v in 5..6.
        n = 0;
        while (pixel_x2 != 10'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hsync2_x10", hsync2, 1);
        n = 0;
        while (pixel_x2 != 10'd13 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hsync2_x13", hsync2, 0);

        n = 0;
        while (vsync2 == 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("vsync2_rise_y", pixel_y2, 5);
        chk("vsync2_rise_x", pixel_x2, 0);
        n = 0;
        while (vsync2 == 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("vsync2_high_clks", n, 90);
        chk("vsync2_fall_y", pixel_y2, 7);
        t_rise = n;
        while (vsync2 == 1'b0 && t_rise < 1000) begin
            @(negedge clk);
            t_rise++;
        end
        chk("vsync2_period_clks", t_rise, 405);

        n = 0;
        while (!(pixel_x2 == 10'd14 && pixel_y2 == 10'd8) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reach2_14_8", (pixel_x2 == 10'd14 && pixel_y2 == 10'd8) ? 1 : 0, 1);
        n = 0;
        while (p_tick2 == 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("ptick2_at_14_8", p_tick2, 1);
`ifdef VGA_FRAME_TICK_EN
        chk("frame_tick2_at_wrap", frame_tick2, 1);
`endif
        @(negedge clk);
        chk("wrap2_x", pixel_x2, 0);
        chk("wrap2_y", pixel_y2, 0);
`ifdef VGA_FRAME_TICK_EN
        n = 0;
        for (int c = 0; c < 405; c++) begin
            chk("frame_tick2_off_wrap", frame_tick2, (pixel_x2 == 10'd14 && pixel_y2 == 10'd8 && p_tick2) ? 1 : 0);
            if (frame_tick2) n++;
            @(negedge clk);
        end
        chk("frame_tick2_per_frame", n, 1);
        chk("frame_tick_main_count", ft_main_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing for the video pipeline: pixel-rate tick, horizontal/vertical sync, active-video flag and current pixel coordinates.
- Sits directly upstream of the graphics generator and the top-level RGB output register; those consume p_tick, video_on, pixel_x and pixel_y.
- Default timing is 640x480 at 60 Hz from a 100 MHz system clock (÷4 gives a 25 MHz pixel rate).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 4, system clocks per pixel; must be ≥2
- SYNC_ACTIVE, 0, logic level of hsync/vsync while asserted

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- video_on  output  1  high while (pixel_x < H_DISPLAY) and (pixel_y < V_DISPLAY)
- p_tick  output  1  one-clk pulse at pixel rate
- pixel_x  output  10  current column, 0..H_TOTAL-1
- pixel_y  output  10  current row, 0..V_TOTAL-1

Behaviour:
- Reset: clk and reset only (one clock; reset is asynchronous and active-high). All state clears immediately on reset assertion, independent of clk.
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset values:
  - divider = 0, h_cnt = 0, v_cnt = 0
  - p_tick = 0
  - hsync = vsync = ~SYNC_ACTIVE (i.e. 1 by default)
  - pixel_x = pixel_y = 0; video_on = 1
- Divider:
  - Counts 0..TICK_DIV-1 every clk and wraps.
  - p_tick is registered and high for exactly one clk when the divider wraps.
  - First p_tick occurs TICK_DIV clks after reset release.
- Horizontal counter: advances only in a clk where p_tick = 1; wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Advances only in a clk where p_tick = 1 and h_cnt = H_TOTAL-1; wraps from V_TOTAL-1 to 0.
  - Simultaneous wrap of both counters → (0,0).
- pixel_x = h_cnt and pixel_y = v_cnt, driven directly from the counter registers.
- Sync generation:
  - hsync and vsync are registered from the next-state counter values, so they change in the same clk as pixel_x/pixel_y (zero skew, no extra latency).
  - hsync = SYNC_ACTIVE when H_DISPLAY+H_FRONT ≤ h_cnt ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = SYNC_ACTIVE when V_DISPLAY+V_FRONT ≤ v_cnt ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- video_on is combinational from the counter registers.
- Counters hold between ticks; all outputs other than p_tick are stable for TICK_DIV clks per pixel.
- Reset mid-frame: immediate return to reset values; the raster restarts at (0,0) with a full divider period before the first tick.
- Frame period: H_TOTAL·V_TOTAL·TICK_DIV clks (1,680,000 by default).

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- Defined:
  - Adds output frame_tick (1 bit, registered, reset 0).
  - frame_tick pulses for one clk, coincident with the p_tick on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Used downstream for once-per-frame animation updates.
- Undefined: port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hold reset 5 clks, release → hsync=1, vsync=1, pixel_x=0, pixel_y=0, p_tick=0; first p_tick at clk 4 after release, then every 4 clks, each pulse 1 clk wide.
- Run to pixel_x=799 at pixel_y=0, next p_tick → pixel_x=0, pixel_y=1; video_on: 1 at x=639, 0 at x=640, 1 again at x=0.
- Count one line → hsync low for exactly 96 ticks (384 clks), falling in the same clk pixel_x becomes 656 and rising when pixel_x becomes 752.
- Run one frame → vsync low exactly while pixel_y ∈ {490, 491} (1600 ticks); (799,524) → (0,0); successive vsync falling edges 1,680,000 clks apart.
- Assert reset asynchronously (between clk edges) at pixel (300,200) → outputs return to reset values before the next clk edge; after release, raster restarts at (0,0) with the 4-clk tick latency.
- With VGA_FRAME_TICK_EN defined → exactly one 1-clk frame_tick per 1,680,000 clks, coincident with the (0,0) transition; never asserted during reset.
